// File: rtl/onchip_memory_stream_reader_if.sv
// ---------------------------------------------------------------------------
// onchip_memory_stream_reader_if
//
// Bus bundle for onchip_memory_stream_reader: the Avalon-MM read port facing
// the on-chip RAM slave (s1) and the Avalon-ST source carrying the words out.
//
// Signals
//   mem_address       RAM word address            (master -> slave)
//   mem_chipselect    read strobe                 (master -> slave)
//   mem_clken         RAM clock enable            (master -> slave)
//   mem_write         write strobe, always 0      (master -> slave)
//   mem_byteenable    byte enables, always 4'hF   (master -> slave)
//   mem_readdata      RAM q, 1-clk read latency   (slave  -> master)
//   src_data          stream data                 (master -> slave)
//   src_valid         stream valid                (master -> slave)
//   src_ready         stream ready                (slave  -> master)
//   src_startofpacket first word of the packet    (master -> slave)
//   src_endofpacket   last word of the packet     (master -> slave)
//
// Modports: master (the reader), slave (RAM + stream sink side).
// ---------------------------------------------------------------------------
interface onchip_memory_stream_reader_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_startofpacket;
    logic              src_endofpacket;

    modport master (
        output mem_address, mem_chipselect, mem_clken, mem_write, mem_byteenable,
        input  mem_readdata,
        output src_data, src_valid, src_startofpacket, src_endofpacket,
        input  src_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_clken, mem_write, mem_byteenable,
        output mem_readdata,
        input  src_data, src_valid, src_startofpacket, src_endofpacket,
        output src_ready
    );
endinterface

// File: rtl/onchip_memory_stream_reader.sv
// ---------------------------------------------------------------------------
// onchip_memory_stream_reader
//
// Avalon-MM read master in front of a 32-bit single-port on-chip RAM. A start
// pulse reads word_count consecutive words from base_addr (wrapping at
// MEM_DEPTH-1 -> 0) and emits them in order as one Avalon-ST packet. A small
// read-ahead FIFO hides the RAM's 1-clk read latency so a continuously ready
// sink receives one word per clock.
//
// Ports
//   clk          single clock, shared with the RAM
//   reset_n      asynchronous active-low reset
//   start        1-clk job request, ignored while busy
//   base_addr    first word address, sampled with start
//   word_count   number of words, sampled with start (0 = empty job)
//   busy         high from the clk after start until the job ends
//   done         1-clk pulse at job end
//   bus          memory read port + stream source (master modport)
//   checksum     mod-2^32 sum of transferred words (only with macro below)
//
// Build option: define ONCHIP_RD_CHECKSUM_EN to add the checksum port.
// ---------------------------------------------------------------------------
module onchip_memory_stream_reader #(
    parameter int unsigned MEM_DEPTH  = 32000,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    output logic              busy,
    output logic              done,
    onchip_memory_stream_reader_if.master bus
`ifdef ONCHIP_RD_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       issue_left_q;
    logic [15:0]       recv_left_q;
    logic [15:0]       count_q;
    logic              inflight_q;
    logic              busy_q;
    logic              done_q;

    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic              fifo_sop_q  [FIFO_DEPTH];
    logic              fifo_eop_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;

    logic [CNT_W-1:0]  occ;
    logic              issue, push, pop;

    // Words already buffered plus the one read still in the RAM pipeline
    // must leave room, so a read is never issued without a FIFO slot for it.
    always_comb begin
        occ    = fifo_cnt_q + CNT_W'(inflight_q);
        issue  = (state_q == S_RUN) && (occ < CNT_W'(FIFO_DEPTH));
        push   = inflight_q;
        pop    = (fifo_cnt_q != '0) && bus.src_ready;
        addr_d = (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            recv_left_q  <= '0;
            count_q      <= '0;
            inflight_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_sop_q[i]  <= 1'b0;
                fifo_eop_q[i]  <= 1'b0;
            end
        end else begin
            inflight_q <= issue;

            // Word index is implied by recv_left: first push sees the full
            // count, last push sees 1.
            if (push) begin
                fifo_data_q[wr_ptr_q] <= bus.mem_readdata;
                fifo_sop_q[wr_ptr_q]  <= (recv_left_q == count_q);
                fifo_eop_q[wr_ptr_q]  <= (recv_left_q == 16'd1);
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
                recv_left_q           <= recv_left_q - 16'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q       <= 1'b1;
                        addr_q       <= base_addr;
                        issue_left_q <= word_count;
                        recv_left_q  <= word_count;
                        count_q      <= word_count;
                        if (word_count == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        addr_q       <= addr_d;
                        issue_left_q <= issue_left_q - 16'd1;
                        if (issue_left_q == 16'd1) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && fifo_eop_q[rd_ptr_q]) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign bus.mem_address       = addr_q;
    assign bus.mem_chipselect    = issue;
    assign bus.mem_clken         = 1'b1;
    assign bus.mem_write         = 1'b0;
    assign bus.mem_byteenable    = 4'hF;
    assign bus.src_data          = fifo_data_q[rd_ptr_q];
    assign bus.src_valid         = (fifo_cnt_q != '0);
    assign bus.src_startofpacket = (fifo_cnt_q != '0) && fifo_sop_q[rd_ptr_q];
    assign bus.src_endofpacket   = (fifo_cnt_q != '0) && fifo_eop_q[rd_ptr_q];

`ifdef ONCHIP_RD_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q + 32'(bus.src_data);
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
